// File: rtl/gpio_in_conditioner_pkg.sv
// gpin_pkg: register map and default sizing for the
// GPIO input conditioner.
package gpin_pkg;

  localparam logic [1:0] GPIN_STATE = 2'd0;
  localparam logic [1:0] GPIN_FLAGS = 2'd1;
  localparam logic [1:0] GPIN_MASK  = 2'd2;
  localparam logic [1:0] GPIN_POL   = 2'd3;

  localparam int GPIN_WIDTH    = 8;
  localparam int GPIN_PRESCALE = 1000;
  localparam int GPIN_DB_TICKS = 4;

endpackage

// File: rtl/gpio_in_conditioner_if.sv
// gpin_if: CPU register port of the GPIO input conditioner
// (select, write strobe, index, data both ways, interrupt).
interface gpin_if;

  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (
    output cs, we, addr, din,
    input  dout, irq
  );

  modport slave (
    input  cs, we, addr, din,
    output dout, irq
  );

endinterface

// File: rtl/gpin_debounce_bit.sv
// gpin_debounce_bit: 2-flop synchroniser plus tick-based
// debounce counter for one pin, with accepted-edge pulses.
module gpin_debounce_bit #(
  parameter int DB_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  input  logic tick_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(DB_TICKS + 1);

  logic          s1_q;
  logic          s2_q;
  logic          st_q;
  logic          st_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept;

  assign accept = tick_i & (s2_q != st_q)
                & (cnt_q == CW'(DB_TICKS - 1));

  // Count disagreeing ticks; agreement restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    st_d  = st_q;
    if (s2_q == st_q) begin
      cnt_d = '0;
    end else if (accept) begin
      st_d  = s2_q;
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser, debounced level and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      st_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= pin_i;
      s2_q  <= s1_q;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign state_o = st_q;
  assign rise_o  = accept & s2_q;
  assign fall_o  = accept & ~s2_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: debounced GPIO inputs with sticky edge
// flags; GPIN_IRQ_EN adds the mask register and irq output.
module gpio_in_conditioner
  import gpin_pkg::*;
#(
  parameter int WIDTH    = GPIN_WIDTH,
  parameter int PRESCALE = GPIN_PRESCALE,
  parameter int DB_TICKS = GPIN_DB_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] gpio_i,
  gpin_if.slave            bus
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0]    pre_q;
  logic [PW-1:0]    pre_d;
  logic             tick;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] flags_q;
  logic [WIDTH-1:0] flags_d;
  logic [WIDTH-1:0] pol_q;
  logic [WIDTH-1:0] pol_d;
  logic [7:0]       dout_q;
  logic [7:0]       dout_d;
  logic [7:0]       rdata;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] wdata;
`ifdef GPIN_IRQ_EN
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
`endif

  assign tick  = (pre_q == PW'(PRESCALE - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);
  assign wr    = bus.cs & bus.we;
  assign rd    = bus.cs & ~bus.we;
  assign wdata = bus.din[WIDTH-1:0];

  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    gpin_debounce_bit #(
      .DB_TICKS(DB_TICKS)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .pin_i  (pins_i[g]),
      .tick_i (tick),
      .state_o(gpio_i[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  // Flag on the polarity-selected edge; a new edge beats W1C.
  always_comb begin
    set     = (rise & ~pol_q) | (fall & pol_q);
    clr     = '0;
    pol_d   = pol_q;
`ifdef GPIN_IRQ_EN
    mask_d  = mask_q;
`endif
    if (wr) begin
      unique case (bus.addr)
        GPIN_FLAGS: clr = wdata;
`ifdef GPIN_IRQ_EN
        GPIN_MASK:  mask_d = wdata;
`endif
        GPIN_POL:   pol_d = wdata;
        default:    ;
      endcase
    end
    flags_d = (flags_q & ~clr) | set;
  end

  // Read mux; bits above WIDTH read as zero.
  always_comb begin
    rdata = '0;
    unique case (bus.addr)
      GPIN_STATE: rdata[WIDTH-1:0] = gpio_i;
      GPIN_FLAGS: rdata[WIDTH-1:0] = flags_q;
`ifdef GPIN_IRQ_EN
      GPIN_MASK:  rdata[WIDTH-1:0] = mask_q;
`else
      GPIN_MASK:  rdata = '0;
`endif
      GPIN_POL:   rdata[WIDTH-1:0] = pol_q;
    endcase
    dout_d = rd ? rdata : dout_q;
  end

  // Prescaler, register file and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q   <= '0;
      flags_q <= '0;
      pol_q   <= '0;
      dout_q  <= '0;
    end else begin
      pre_q   <= pre_d;
      flags_q <= flags_d;
      pol_q   <= pol_d;
      dout_q  <= dout_d;
    end
  end

`ifdef GPIN_IRQ_EN
  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign bus.irq = |(flags_q & mask_q);
`else
  assign bus.irq = 1'b0;
`endif

  assign bus.dout = dout_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner: table vectors, directed corner
// sequences and random pins/bus traffic against a model.
module tb_gpio_in_conditioner;
  import gpin_pkg::*;

  localparam int W  = 8;
  localparam int P  = 4;
  localparam int DB = 3;
`ifdef GPIN_IRQ_EN
  localparam logic [7:0] MASK_RB = 8'hFF;
  localparam logic [7:0] IRQ_ON  = 8'h01;
`else
  localparam logic [7:0] MASK_RB = 8'h00;
  localparam logic [7:0] IRQ_ON  = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pins = 8'h00;
  logic [7:0] gpio;

  gpin_if bus();

  always #5 clk = ~clk;

  gpio_in_conditioner #(
    .WIDTH(W), .PRESCALE(P), .DB_TICKS(DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pins_i(pins),
    .gpio_i(gpio),
    .bus   (bus)
  );

  int nvec = 0;
  int nmis = 0;

  // reference model state
  logic [7:0] m_ph1, m_ph2, m_st, m_fl, m_mk, m_pl, m_do;
  int         m_run[8];
  int         m_k;

  task automatic chk(string nm, logic [7:0] got,
                     logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic rng_chk(string nm, int n, int lo, int hi);
    nvec++;
    if (n < lo || n > hi) begin
      nmis++;
      $display("FAIL %s: got %0d cycles expected %0d..%0d",
               nm, n, lo, hi);
    end
  endtask

  function automatic void m_rst();
    m_ph1 = 0; m_ph2 = 0; m_st = 0; m_fl = 0;
    m_mk = 0; m_pl = 0; m_do = 0; m_k = 0;
    for (int i = 0; i < 8; i++) m_run[i] = 0;
  endfunction

  function automatic logic [7:0] m_read(logic [1:0] a);
    case (a)
      2'd0:    return m_st;
      2'd1:    return m_fl;
`ifdef GPIN_IRQ_EN
      2'd2:    return m_mk;
`endif
      2'd3:    return m_pl;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic m_irq();
`ifdef GPIN_IRQ_EN
    return |(m_fl & m_mk);
`else
    return 1'b0;
`endif
  endfunction

  // one clock edge: a pin level seen two edges ago must disagree
  // with the accepted level for DB consecutive ticks to be taken
  function automatic void m_edge();
    logic       tk;
    logic [7:0] nst;
    logic [7:0] set;
    logic [7:0] clr;
    tk  = (m_k % P) == P - 1;
    nst = m_st;
    set = 0;
    clr = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_ph2[i] != m_st[i]) begin
        if (tk) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            nst[i]   = m_ph2[i];
            m_run[i] = 0;
            if (m_ph2[i] != m_pl[i]) set[i] = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (bus.cs && !bus.we) m_do = m_read(bus.addr);
    if (bus.cs && bus.we) begin
      case (bus.addr)
        2'd1: clr = bus.din;
`ifdef GPIN_IRQ_EN
        2'd2: m_mk = bus.din;
`endif
        2'd3: m_pl = bus.din;
        default: ;
      endcase
    end
    m_fl  = (m_fl & ~clr) | set;
    m_st  = nst;
    m_ph2 = m_ph1;
    m_ph1 = pins;
    m_k++;
  endfunction

  function automatic logic will_accept(int i);
    return ((m_k % P) == P - 1) && (m_ph2[i] != m_st[i])
           && (m_run[i] == DB - 1);
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (reset) m_edge();
    #1;
    chk("gpio_i", gpio, m_st);
    chk("dout", bus.dout, m_do);
    chk("irq", {7'b0, bus.irq}, {7'b0, m_irq()});
  endtask

  task automatic idle(int n);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    m_rst();
    #1;
    chk("rst_gpio", gpio, 8'h00);
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_irq", {7'b0, bus.irq}, 8'h00);
  endtask

  task automatic wr(logic [1:0] a, logic [7:0] d);
    bus.cs = 1'b1; bus.we = 1'b1;
    bus.addr = a; bus.din = d;
    cyc();
    bus.cs = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rdchk(string nm, logic [1:0] a,
                       logic [7:0] e);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    cyc();
    bus.cs = 1'b0;
    chk(nm, bus.dout, e);
  endtask

  task automatic wait_gpio(int i, logic v, int maxc,
                           output int n);
    n = 0;
    while (gpio[i] !== v && n < maxc) begin
      cyc();
      n++;
    end
    if (gpio[i] !== v) begin
      nvec++;
      nmis++;
      $display("FAIL wait_gpio%0d: got %b expected %b", i,
               gpio[i], v);
    end
  endtask

  typedef struct {
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    int idx;
    bit hit;

    tbl[0] = '{GPIN_POL,   8'hA5, 8'hA5};
    tbl[1] = '{GPIN_POL,   8'h3C, 8'h3C};
    tbl[2] = '{GPIN_POL,   8'h00, 8'h00};
    tbl[3] = '{GPIN_STATE, 8'hFF, 8'h00};
    tbl[4] = '{GPIN_FLAGS, 8'hFF, 8'h00};
    tbl[5] = '{GPIN_MASK,  8'hFF, MASK_RB};
    tbl[6] = '{GPIN_MASK,  8'h00, 8'h00};

    bus.cs = 1'b0; bus.we = 1'b0;
    bus.addr = 2'd0; bus.din = 8'h00;
    do_reset();
    idle(3);
    reset = 1'b1;
    idle(5);

    for (int i = 0; i < 7; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rdchk("tbl_read", tbl[i].addr, tbl[i].exp);
    end

    // reset in the middle of a count discards it
    pins = 8'h01;
    idle(6);
    do_reset();
    idle(3);
    chk("rst_hold_gpio", gpio, 8'h00);
    reset = 1'b1;
    wait_gpio(0, 1'b1, 30, n);
    rng_chk("rise_latency", n, 2 + (DB - 1) * P + 1,
            2 + DB * P);
    rdchk("flag0", GPIN_FLAGS, 8'h01);

    // bouncing input is never accepted
    wr(GPIN_FLAGS, 8'hFF);
    for (int t = 0; t < 12; t++) begin
      pins[3] = ~pins[3];
      repeat (5) begin
        cyc();
        chk("bounce_gpio3", {7'b0, gpio[3]}, 8'h00);
      end
    end
    rdchk("bounce_flags", GPIN_FLAGS, 8'h00);
    pins[3] = 1'b1;
    wait_gpio(3, 1'b1, 30, n);
    idle(1);
    rdchk("flag3", GPIN_FLAGS, 8'h08);

    // falling-edge polarity on bit 2
    wr(GPIN_FLAGS, 8'hFF);
    wr(GPIN_POL, 8'h04);
    pins[2] = 1'b1;
    wait_gpio(2, 1'b1, 30, n);
    idle(1);
    rdchk("pol_rise_ignored", GPIN_FLAGS, 8'h00);
    pins[2] = 1'b0;
    wait_gpio(2, 1'b0, 30, n);
    idle(1);
    rdchk("pol_fall_flag", GPIN_FLAGS, 8'h04);
    wr(GPIN_FLAGS, 8'h04);
    rdchk("w1c_flag2", GPIN_FLAGS, 8'h00);
    wr(GPIN_POL, 8'h00);
    rdchk("pol_change_noflag", GPIN_FLAGS, 8'h00);

    // interrupt set, clear, and W1C racing a new edge
    wr(GPIN_MASK, 8'h01);
    pins[0] = 1'b0;
    wait_gpio(0, 1'b0, 30, n);
    pins[0] = 1'b1;
    wait_gpio(0, 1'b1, 30, n);
    idle(1);
    chk("irq_set", {7'b0, bus.irq}, IRQ_ON);
    wr(GPIN_FLAGS, 8'h01);
    chk("irq_clr", {7'b0, bus.irq}, 8'h00);
    pins[0] = 1'b0;
    wait_gpio(0, 1'b0, 30, n);
    pins[0] = 1'b1;
    hit = 1'b0;
    for (int t = 0; t < 40 && !hit; t++) begin
      if (will_accept(0)) hit = 1'b1;
      else cyc();
    end
    chk("race_found", {7'b0, hit}, 8'h01);
    wr(GPIN_FLAGS, 8'h01);
    chk("race_gpio0", {7'b0, gpio[0]}, 8'h01);
    chk("race_irq", {7'b0, bus.irq}, IRQ_ON);
    rdchk("race_flag", GPIN_FLAGS, 8'h01);
    wr(GPIN_MASK, 8'hFF);
    rdchk("mask_read", GPIN_MASK, MASK_RB);

    // random pins and register traffic
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        do_reset();
        idle(2);
        reset = 1'b1;
      end
      if ($urandom_range(0, 14) == 0) begin
        idx = $urandom_range(0, 7);
        pins[idx] = ~pins[idx];
      end
      if ($urandom_range(0, 5) == 0) begin
        bus.cs = 1'b1;
        bus.we = 1'($urandom_range(0, 1));
        bus.addr = 2'($urandom_range(0, 3));
        bus.din = 8'($urandom);
      end else begin
        bus.cs = 1'b0;
        bus.we = 1'b0;
      end
      cyc();
    end
    bus.cs = 1'b0;
    bus.we = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
